// File: rtl/ram_movie_arbiter.sv
// Round-robin arbiter sharing the movie-RAM port between the manager editor (port 0)
// and the customer purchase flow (port 1). Optional GRANT timeout: define ARB_TIMEOUT_EN.
module ram_movie_arbiter #(
  parameter int OP_W    = 3,
  parameter int IDX_W   = 32,
  parameter int ID_W    = 6,
  parameter int DAT_W   = 46,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_i,
  input  logic [OP_W-1:0]  op0_i,
  input  logic [OP_W-1:0]  op1_i,
  input  logic [IDX_W-1:0] idx0_i,
  input  logic [IDX_W-1:0] idx1_i,
  input  logic [ID_W-1:0]  id0_i,
  input  logic [ID_W-1:0]  id1_i,
  input  logic [DAT_W-1:0] dat0_i,
  input  logic [DAT_W-1:0] dat1_i,
  output logic [1:0]       gnt_o,
  output logic [1:0]       done_o,
  output logic             wrong_o,
  output logic [IDX_W-1:0] rd_num_o,
  output logic [ID_W-1:0]  rd_id_o,
  output logic [DAT_W-1:0] rd_dat_o,
  output logic [OP_W-1:0]  ram_op_o,
  output logic [IDX_W-1:0] ram_idx_o,
  output logic [ID_W-1:0]  ram_id_o,
  output logic [DAT_W-1:0] ram_dat_o,
  input  logic             ram_over_i,
  input  logic             ram_wrong_i,
  input  logic             ram_working_i,
  input  logic [IDX_W-1:0] ram_num_i,
  input  logic [ID_W-1:0]  ram_id_i,
  input  logic [DAT_W-1:0] ram_dat_i
);

  localparam logic [OP_W-1:0] NOP = '1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DONE, S_DRAIN} state_t;

  state_t r_state;
  state_t w_next;

  logic             r_ptr;
  logic             r_win;
  logic [1:0]       r_gnt;
  logic [1:0]       r_done;
  logic             r_wrong;
  logic [IDX_W-1:0] r_rd_num;
  logic [ID_W-1:0]  r_rd_id;
  logic [DAT_W-1:0] r_rd_dat;
  logic [OP_W-1:0]  r_ram_op;
  logic [IDX_W-1:0] r_ram_idx;
  logic [ID_W-1:0]  r_ram_id;
  logic [DAT_W-1:0] r_ram_dat;

  logic w_win;
  logic w_nop;
  logic w_cap;
  logic w_fail;
  logic w_timeout;

  // Single requester wins outright; on a tie the pointer decides.
  always_comb begin
    w_win = r_ptr;
    if (req_i == 2'b01)
      w_win = 1'b0;
    else if (req_i == 2'b10)
      w_win = 1'b1;
  end

  // A granted no-op leaves NOP latched on the RAM op, so it never reaches the RAM.
  assign w_nop = (r_ram_op == NOP);

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= 8'd0;
    else if (r_state == S_GRANT && w_next == S_GRANT)
      r_cnt <= r_cnt + 8'd1;
    else
      r_cnt <= 8'd0;
  end

  assign w_timeout = (r_cnt == TIMEOUT_CNT);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_cap  = 1'b0;
    w_fail = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((|req_i) && !ram_working_i)
          w_next = S_GRANT;
      end
      S_GRANT: begin
        if (w_nop) begin
          w_next = S_DONE;
          w_fail = 1'b1;
        end else if (ram_over_i) begin
          w_next = S_DONE;
          w_cap  = 1'b1;
        end else if (w_timeout) begin
          w_next = S_DONE;
          w_fail = 1'b1;
        end
      end
      S_DONE: w_next = S_DRAIN;
      S_DRAIN: begin
        // Held request or level-style over must drop before re-arbitrating.
        if (!req_i[r_win] && !ram_over_i)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= 1'b0;
      r_win     <= 1'b0;
      r_gnt     <= 2'b00;
      r_done    <= 2'b00;
      r_wrong   <= 1'b0;
      r_rd_num  <= '0;
      r_rd_id   <= '0;
      r_rd_dat  <= '0;
      r_ram_op  <= NOP;
      r_ram_idx <= '0;
      r_ram_id  <= '0;
      r_ram_dat <= '0;
    end else begin
      r_done <= 2'b00;
      if (r_state == S_IDLE && w_next == S_GRANT) begin
        r_win     <= w_win;
        r_gnt     <= w_win ? 2'b10 : 2'b01;
        r_ram_op  <= w_win ? op1_i  : op0_i;
        r_ram_idx <= w_win ? idx1_i : idx0_i;
        r_ram_id  <= w_win ? id1_i  : id0_i;
        r_ram_dat <= w_win ? dat1_i : dat0_i;
      end
      if (r_state == S_GRANT && w_next == S_DONE) begin
        r_gnt    <= 2'b00;
        r_done   <= r_win ? 2'b10 : 2'b01;
        r_ptr    <= ~r_win;
        r_ram_op <= NOP;
        r_wrong  <= w_fail | ram_wrong_i & w_cap;
        if (w_cap) begin
          r_rd_num <= ram_num_i;
          r_rd_id  <= ram_id_i;
          r_rd_dat <= ram_dat_i;
        end
      end
    end
  end

  assign gnt_o     = r_gnt;
  assign done_o    = r_done;
  assign wrong_o   = r_wrong;
  assign rd_num_o  = r_rd_num;
  assign rd_id_o   = r_rd_id;
  assign rd_dat_o  = r_rd_dat;
  assign ram_op_o  = r_ram_op;
  assign ram_idx_o = r_ram_idx;
  assign ram_id_o  = r_ram_id;
  assign ram_dat_o = r_ram_dat;

endmodule

// File: tb/tb_ram_movie_arbiter.sv
// Directed bench for ram_movie_arbiter: reset, single and contended transactions,
// RAM error, no-op request, busy RAM, mid-transaction reset and GRANT hold/timeout.
module tb_ram_movie_arbiter;

  localparam int OP_W  = 3;
  localparam int IDX_W = 32;
  localparam int ID_W  = 6;
  localparam int DAT_W = 46;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_i;
  logic [OP_W-1:0]  op0_i, op1_i;
  logic [IDX_W-1:0] idx0_i, idx1_i;
  logic [ID_W-1:0]  id0_i, id1_i;
  logic [DAT_W-1:0] dat0_i, dat1_i;
  logic [1:0]       gnt_o, done_o;
  logic             wrong_o;
  logic [IDX_W-1:0] rd_num_o;
  logic [ID_W-1:0]  rd_id_o;
  logic [DAT_W-1:0] rd_dat_o;
  logic [OP_W-1:0]  ram_op_o;
  logic [IDX_W-1:0] ram_idx_o;
  logic [ID_W-1:0]  ram_id_o;
  logic [DAT_W-1:0] ram_dat_o;
  logic             ram_over_i, ram_wrong_i, ram_working_i;
  logic [IDX_W-1:0] ram_num_i;
  logic [ID_W-1:0]  ram_id_i;
  logic [DAT_W-1:0] ram_dat_i;

  int n_cmp = 0;
  int n_err = 0;

  ram_movie_arbiter #(
    .OP_W(OP_W), .IDX_W(IDX_W), .ID_W(ID_W), .DAT_W(DAT_W), .TIMEOUT(10)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i),
    .op0_i(op0_i), .op1_i(op1_i), .idx0_i(idx0_i), .idx1_i(idx1_i),
    .id0_i(id0_i), .id1_i(id1_i), .dat0_i(dat0_i), .dat1_i(dat1_i),
    .gnt_o(gnt_o), .done_o(done_o), .wrong_o(wrong_o),
    .rd_num_o(rd_num_o), .rd_id_o(rd_id_o), .rd_dat_o(rd_dat_o),
    .ram_op_o(ram_op_o), .ram_idx_o(ram_idx_o), .ram_id_o(ram_id_o), .ram_dat_o(ram_dat_o),
    .ram_over_i(ram_over_i), .ram_wrong_i(ram_wrong_i), .ram_working_i(ram_working_i),
    .ram_num_i(ram_num_i), .ram_id_i(ram_id_i), .ram_dat_i(ram_dat_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_g;
    rst = 1'b1; req_i = 2'b00;
    op0_i = 3'd0; op1_i = 3'd0; idx0_i = '0; idx1_i = '0;
    id0_i = '0; id1_i = '0; dat0_i = '0; dat1_i = '0;
    ram_over_i = 1'b0; ram_wrong_i = 1'b0; ram_working_i = 1'b0;
    ram_num_i = '0; ram_id_i = '0; ram_dat_i = '0;
    @(negedge clk);
    tick(2);
    chk("rst_op", ram_op_o, 3'b111);
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_done", done_o, 2'b00);
    chk("rst_wrong", wrong_o, 1'b0);
    chk("rst_rd_num", rd_num_o, 0);
    chk("rst_rd_id", rd_id_o, 0);
    chk("rst_rd_dat", rd_dat_o, 0);
    rst = 1'b0;
    tick(1);

    // Single port-0 transaction
    req_i = 2'b01; op0_i = 3'b001; id0_i = 6'd5; idx0_i = 32'd7; dat0_i = 46'h3ABC;
    tick(1);
    chk("t2_gnt", gnt_o, 2'b01);
    chk("t2_ram_id", ram_id_o, 6'd5);
    chk("t2_ram_op", ram_op_o, 3'b001);
    chk("t2_ram_idx", ram_idx_o, 32'd7);
    chk("t2_ram_dat", ram_dat_o, 46'h3ABC);
    id0_i = 6'd33; op0_i = 3'b010;
    tick(3);
    chk("t2_frozen_id", ram_id_o, 6'd5);
    chk("t2_frozen_op", ram_op_o, 3'b001);
    chk("t2_gnt_hold", gnt_o, 2'b01);
    ram_over_i = 1'b1; ram_dat_i = 46'h1234; ram_num_i = 32'd3; ram_id_i = 6'd9;
    tick(1);
    chk("t2_done", done_o, 2'b01);
    chk("t2_gnt_clr", gnt_o, 2'b00);
    chk("t2_rd_dat", rd_dat_o, 46'h1234);
    chk("t2_rd_num", rd_num_o, 32'd3);
    chk("t2_rd_id", rd_id_o, 6'd9);
    chk("t2_wrong", wrong_o, 1'b0);
    chk("t2_op_idle", ram_op_o, 3'b111);
    ram_over_i = 1'b0; req_i = 2'b00;
    tick(1);
    chk("t2_done_pulse", done_o, 2'b00);
    tick(1);

    // Contention: pointer now favours port 1 after port 0's completion
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
      req_i = 2'b11; op0_i = 3'b011; op1_i = 3'b100;
      tick(1);
      chk("t3_gnt", gnt_o, exp_g);
      chk("t3_op", ram_op_o, exp_g[1] ? 3'b100 : 3'b011);
      tick(2);
      ram_over_i = 1'b1;
      tick(1);
      chk("t3_done", done_o, exp_g);
      ram_over_i = 1'b0; req_i = req_i & ~exp_g;
      tick(2);
      chk("t3_no_regrant", gnt_o, 2'b00);
    end

    // RAM error, then a clean transaction clears it
    req_i = 2'b01; op0_i = 3'b001;
    tick(1);
    chk("t4_gnt", gnt_o, 2'b01);
    ram_over_i = 1'b1; ram_wrong_i = 1'b1; ram_dat_i = 46'h5A5A;
    tick(1);
    chk("t4_done", done_o, 2'b01);
    chk("t4_wrong", wrong_o, 1'b1);
    chk("t4_rd_dat", rd_dat_o, 46'h5A5A);
    ram_over_i = 1'b0; ram_wrong_i = 1'b0; req_i = 2'b00;
    tick(2);
    chk("t4_wrong_hold", wrong_o, 1'b1);
    req_i = 2'b10; op1_i = 3'b010;
    tick(1);
    chk("t4b_gnt", gnt_o, 2'b10);
    chk("t4b_op", ram_op_o, 3'b010);
    ram_over_i = 1'b1; ram_num_i = 32'd42;
    tick(1);
    chk("t4b_done", done_o, 2'b10);
    chk("t4b_wrong", wrong_o, 1'b0);
    chk("t4b_rd_num", rd_num_o, 32'd42);
    ram_over_i = 1'b0; req_i = 2'b00;
    tick(2);

    // No-op request completes on its own with the error flag
    req_i = 2'b01; op0_i = 3'b111;
    tick(1);
    chk("nop_gnt", gnt_o, 2'b01);
    chk("nop_op", ram_op_o, 3'b111);
    tick(1);
    chk("nop_done", done_o, 2'b01);
    chk("nop_wrong", wrong_o, 1'b1);
    chk("nop_rd_num", rd_num_o, 32'd42);
    req_i = 2'b00;
    tick(2);

    // Over while idle is ignored; busy RAM blocks the grant
    ram_over_i = 1'b1; ram_num_i = 32'd99;
    tick(1);
    chk("idle_over_done", done_o, 2'b00);
    chk("idle_over_rd", rd_num_o, 32'd42);
    ram_over_i = 1'b0;
    ram_working_i = 1'b1; req_i = 2'b01; op0_i = 3'b001;
    tick(1);
    chk("busy_gnt", gnt_o, 2'b00);
    ram_working_i = 1'b0;
    tick(1);
    chk("busy_release_gnt", gnt_o, 2'b01);

    // Reset mid-GRANT: no done, op back to NOP, pointer back to port 0
    req_i = 2'b11; rst = 1'b1;
    tick(1);
    chk("t5_op", ram_op_o, 3'b111);
    chk("t5_gnt", gnt_o, 2'b00);
    chk("t5_done", done_o, 2'b00);
    chk("t5_rd_num", rd_num_o, 0);
    rst = 1'b0;
    tick(1);
    chk("t5_ptr_gnt", gnt_o, 2'b01);
    chk("t5_done_after", done_o, 2'b00);

`ifdef ARB_TIMEOUT_EN
    tick(10);
    chk("t6_gnt_hold", gnt_o, 2'b01);
    tick(1);
    chk("t6_to_done", done_o, 2'b01);
    chk("t6_to_wrong", wrong_o, 1'b1);
    chk("t6_to_rd", rd_num_o, 0);
`else
    tick(20);
    chk("t6_gnt_hold", gnt_o, 2'b01);
    chk("t6_no_done", done_o, 2'b00);
    ram_over_i = 1'b1; ram_num_i = 32'd11;
    tick(1);
    chk("t6_done", done_o, 2'b01);
    chk("t6_rd_num", rd_num_o, 32'd11);
`endif
    ram_over_i = 1'b0; req_i = 2'b00;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
